// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, stall/redirect, IF/ID outputs
// Optional misaligned-redirect check enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic {REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic        kill;
  logic        ack_v;
  logic        advance;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic [31:0] deliver_data;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
  logic        squash;
  assign misalign = |redirect_pc[1:0];
  assign target   = {redirect_pc[31:2], 2'b00};
`else
  assign target   = redirect_pc;
`endif

  // An ack only counts against a request that is actually on the bus.
  assign ack_v        = imem_req & imem_ack;
  assign pc_inc       = pc + 32'd4;
  assign deliver_data = (state == HOLD) ? hold_buf : imem_rdata;
  assign advance      = !stall && ((state == HOLD) || (ack_v && !kill));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      hold_buf    <= 32'h0;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      pc_out      <= 32'h0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
      squash         <= 1'b0;
`endif
    end else if (redirect) begin
      pc          <= target;
      state       <= REQ;
      pc_out      <= 32'h0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      // An unacked request must stay on the bus; its data is dropped when it returns.
      if (state == REQ && imem_req && !imem_ack) begin
        kill <= 1'b1;
      end else begin
        kill      <= 1'b0;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (misalign) fetch_misalign <= 1'b1;
      squash <= misalign;
`endif
    end else if (advance) begin
      pc          <= pc_inc;
      state       <= REQ;
      imem_req    <= 1'b1;
      imem_addr   <= pc_inc;
      pc_out      <= pc_inc;
      instr_out   <= deliver_data;
      instr_valid <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (squash) begin
        pc_out      <= 32'h0;
        instr_out   <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
      squash <= 1'b0;
`endif
    end else if (state == REQ) begin
      if (ack_v && !kill) begin
        // Stalled with fresh data: park it and drop the request.
        hold_buf <= imem_rdata;
        state    <= HOLD;
        imem_req <= 1'b0;
      end else begin
        if (ack_v) kill <= 1'b0;
        if (ack_v || !imem_req) imem_addr <= pc;
        imem_req <= 1'b1;
        if (!stall) begin
          pc_out      <= 32'h0;
          instr_out   <= NOP_INSTR;
          instr_valid <= 1'b0;
        end
      end
    end
  end

endmodule
